// File: rtl/life_pkg.sv
// Shared types and grid constants for the Game of Life generation sequencer.
package life_pkg;

  localparam int GRID_CELLS = 64;
  localparam int IDX_W      = 6;
  localparam int XY_W       = 7;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(GRID_CELLS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LDX,
    LDY,
    TOGGLE,
    CALC,
    COMMIT,
    DRAW,
    FLUSH
  } life_state_t;

  function automatic logic is_sweep(input life_state_t s);
    return (s == CALC) || (s == COMMIT) || (s == DRAW);
  endfunction

endpackage

// File: rtl/life_rate_div.sv
// Auto-run rate divider: one-cycle tick every GEN_PERIOD cycles while run is high.
module life_rate_div #(
  parameter int GEN_PERIOD = 12_500_000
) (
  input  logic clk,
  input  logic resetN,
  input  logic run,
  output logic tick
);

  localparam int                CNT_W  = $clog2(GEN_PERIOD);
  localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(GEN_PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_cnt <= RELOAD;
    end else if (!run || (r_cnt == '0)) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign tick = run && (r_cnt == '0);

endmodule

// File: rtl/life_ctrl.sv
// Generation sequencer driving the Life datapath sweeps and the VGA plot strobe.
// Define LIFE_CTRL_AUTORUN_EN to include the run-driven rate divider.
module life_ctrl
  import life_pkg::*;
#(
  parameter int GEN_PERIOD = 12_500_000
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic            step,
  input  logic            run,
  input  logic            ld_x_key,
  input  logic            ld_y_key,
  input  logic            toggle_key,
  output logic            ld_x,
  output logic            ld_y,
  output logic            update_single,
  output logic            update_temp,
  output logic            update_grid,
  output logic            drw,
  output logic [XY_W-1:0] xy_position,
  output logic            plot,
  output logic            busy,
  output logic [7:0]      gen_count
);

  life_state_t      r_state, w_next_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_pend;
  logic [7:0]       r_gen_cnt;
  logic             w_tick, w_req, w_idx_last;

  logic w_ld_x, w_ld_y, w_single, w_temp, w_grid, w_drw, w_busy, w_sweep;
  logic r_ld_x, r_ld_y, r_single, r_temp, r_grid, r_drw, r_plot, r_busy;
  logic [XY_W-1:0] r_xy;

`ifdef LIFE_CTRL_AUTORUN_EN
  life_rate_div #(
    .GEN_PERIOD (GEN_PERIOD)
  ) u_rate_div (
    .clk    (clk),
    .resetN (resetN),
    .run    (run),
    .tick   (w_tick)
  );
`else
  logic w_unused_cfg;
  assign w_unused_cfg = run & (GEN_PERIOD >= 256);
  assign w_tick       = 1'b0;
`endif

  assign w_req      = step | w_tick;
  assign w_idx_last = (r_idx == IDX_LAST);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (ld_x_key)             w_next_state = LDX;
        else if (ld_y_key)        w_next_state = LDY;
        else if (toggle_key)      w_next_state = TOGGLE;
        else if (w_req || r_pend) w_next_state = CALC;
      end
      LDX, LDY: w_next_state = IDLE;
      TOGGLE:   w_next_state = DRAW;
      CALC:     if (w_idx_last) w_next_state = COMMIT;
      COMMIT:   if (w_idx_last) w_next_state = DRAW;
      DRAW:     if (w_idx_last) w_next_state = FLUSH;
      FLUSH:    w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  // Requests that cannot start a generation right now collapse into one pending flag.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_idx     <= '0;
      r_pend    <= 1'b0;
      r_gen_cnt <= '0;
    end else begin
      if (w_next_state != r_state) r_idx <= '0;
      else if (is_sweep(r_state))  r_idx <= r_idx + 1'b1;

      if ((r_state == IDLE) && (w_next_state == CALC)) r_pend <= 1'b0;
      else if (w_req)                                  r_pend <= 1'b1;

      if ((r_state == COMMIT) && w_idx_last) r_gen_cnt <= r_gen_cnt + 8'd1;
    end
  end

  always_comb begin
    w_ld_x   = (r_state == LDX);
    w_ld_y   = (r_state == LDY);
    w_single = (r_state == TOGGLE);
    w_temp   = (r_state == CALC);
    w_grid   = (r_state == COMMIT);
    w_drw    = (r_state == DRAW);
    w_busy   = (r_state != IDLE);
    w_sweep  = is_sweep(r_state);
  end

  // Strobes trail the state by one cycle; plot trails drw by one more.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_ld_x   <= 1'b0;
      r_ld_y   <= 1'b0;
      r_single <= 1'b0;
      r_temp   <= 1'b0;
      r_grid   <= 1'b0;
      r_drw    <= 1'b0;
      r_plot   <= 1'b0;
      r_busy   <= 1'b0;
      r_xy     <= '0;
    end else begin
      r_ld_x   <= w_ld_x;
      r_ld_y   <= w_ld_y;
      r_single <= w_single;
      r_temp   <= w_temp;
      r_grid   <= w_grid;
      r_drw    <= w_drw;
      r_plot   <= r_drw;
      r_busy   <= w_busy;
      if (w_sweep) r_xy <= {{(XY_W-IDX_W){1'b0}}, r_idx};
    end
  end

  assign ld_x          = r_ld_x;
  assign ld_y          = r_ld_y;
  assign update_single = r_single;
  assign update_temp   = r_temp;
  assign update_grid   = r_grid;
  assign drw           = r_drw;
  assign plot          = r_plot;
  assign busy          = r_busy;
  assign xy_position   = r_xy;
  assign gen_count     = r_gen_cnt;

endmodule

// File: tb/tb_life_ctrl.sv
// Scoreboard bench for life_ctrl: expected strobes are queued by the stimulus and popped by a monitor.
module tb_life_ctrl;

  localparam int P = 300;

  localparam logic [2:0] K_NONE = 3'd0;
  localparam logic [2:0] K_LDX  = 3'd1;
  localparam logic [2:0] K_LDY  = 3'd2;
  localparam logic [2:0] K_SGL  = 3'd3;
  localparam logic [2:0] K_TMP  = 3'd4;
  localparam logic [2:0] K_GRD  = 3'd5;
  localparam logic [2:0] K_DRW  = 3'd6;

  localparam int S_STEP = 0;
  localparam int S_LDX  = 1;
  localparam int S_LDY  = 2;
  localparam int S_TGL  = 3;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic step = 1'b0, run = 1'b0, ld_x_key = 1'b0, ld_y_key = 1'b0, toggle_key = 1'b0;
  logic ld_x, ld_y, update_single, update_temp, update_grid, drw, plot, busy;
  logic [6:0] xy_position;
  logic [7:0] gen_count;

  always #5 clk = ~clk;

  life_ctrl #(.GEN_PERIOD(P)) dut (
    .clk           (clk),
    .resetN        (resetN),
    .step          (step),
    .run           (run),
    .ld_x_key      (ld_x_key),
    .ld_y_key      (ld_y_key),
    .toggle_key    (toggle_key),
    .ld_x          (ld_x),
    .ld_y          (ld_y),
    .update_single (update_single),
    .update_temp   (update_temp),
    .update_grid   (update_grid),
    .drw           (drw),
    .xy_position   (xy_position),
    .plot          (plot),
    .busy          (busy),
    .gen_count     (gen_count)
  );

  typedef struct packed {
    logic [2:0] kind;
    logic [6:0] xy;
  } rec_t;

  rec_t q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int act_kind();
    int n, k;
    n = 0; k = K_NONE;
    if (ld_x)          begin n++; k = K_LDX; end
    if (ld_y)          begin n++; k = K_LDY; end
    if (update_single) begin n++; k = K_SGL; end
    if (update_temp)   begin n++; k = K_TMP; end
    if (update_grid)   begin n++; k = K_GRD; end
    if (drw)           begin n++; k = K_DRW; end
    return (n > 1) ? 7 : k;
  endfunction

  always @(negedge clk) begin : monitor
    int   k;
    rec_t e;
    if (resetN) begin
      k = act_kind();
      if (k != K_NONE) begin
        if (q.size() == 0) begin
          check("unexpected_strobe", k, K_NONE);
        end else begin
          e = q.pop_front();
          check("strobe_kind", k, int'(e.kind));
          if (e.kind >= K_TMP) check("strobe_xy", int'(xy_position), int'(e.xy));
        end
      end
    end
  end

  task automatic push_one(input logic [2:0] k, input int x);
    rec_t r;
    r.kind = k;
    r.xy   = 7'(x);
    q.push_back(r);
  endtask

  task automatic push_sweep(input logic [2:0] k);
    for (int i = 0; i < 64; i++) push_one(k, i);
  endtask

  task automatic push_gen();
    push_sweep(K_TMP);
    push_sweep(K_GRD);
    push_sweep(K_DRW);
  endtask

  task automatic pulse(input int which);
    @(negedge clk);
    case (which)
      S_STEP:  step = 1'b1;
      S_LDX:   ld_x_key = 1'b1;
      S_LDY:   ld_y_key = 1'b1;
      S_TGL:   toggle_key = 1'b1;
      default: ;
    endcase
    @(negedge clk);
    step = 1'b0; ld_x_key = 1'b0; ld_y_key = 1'b0; toggle_key = 1'b0;
  endtask

  task automatic wait_strobe(input logic [2:0] k, input int x);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 1000 && !seen; t++) begin
      @(negedge clk);
      if ((act_kind() == int'(k)) && (int'(xy_position) == x)) seen = 1'b1;
    end
    check("wait_strobe_timeout", int'(seen), 1);
  endtask

  task automatic measure(output int busy_len, output int plot_cnt);
    int t;
    t = 0; busy_len = 0; plot_cnt = 0;
    while (!busy && t < 50) begin @(negedge clk); t++; end
    while (busy && busy_len < 2000) begin
      busy_len++;
      if (plot) plot_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic count_idle(output int n);
    n = 0;
    while (!busy && n < 50) begin n++; @(negedge clk); end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int bl, pc, ni, rises, last_rise, prev_busy, exp_gen, t;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_xy", int'(xy_position), 0);
    check("rst_gen", int'(gen_count), 0);
    check("rst_plot", int'(plot), 0);
    check("rst_strobes", act_kind(), K_NONE);
    resetN = 1'b1;
    @(negedge clk);

    // One step: full generation
    push_gen();
    pulse(S_STEP);
    check("latency_busy_low", int'(busy), 0);
    @(negedge clk);
    check("first_update_temp", int'(update_temp), 1);
    measure(bl, pc);
    check("gen1_busy_len", bl, 193);
    check("gen1_plot_cnt", pc, 64);
    check("gen1_count", int'(gen_count), 1);
    check("gen1_plot_idle", int'(plot), 0);

    // Step during COMMIT becomes pending
    push_gen();
    push_gen();
    pulse(S_STEP);
    wait_strobe(K_GRD, 10);
    pulse(S_STEP);
    measure(bl, pc);
    count_idle(ni);
    check("pending_idle_gap", ni, 1);
    measure(bl, pc);
    check("pending_busy_len", bl, 193);
    check("pending_plot_cnt", pc, 64);
    check("pending_gen_count", int'(gen_count), 3);

    // ld_x beats toggle in the same cycle
    push_one(K_LDX, 0);
    @(negedge clk);
    ld_x_key = 1'b1; toggle_key = 1'b1;
    @(negedge clk);
    ld_x_key = 1'b0; toggle_key = 1'b0;
    repeat (5) @(negedge clk);
    check("ldx_busy_after", int'(busy), 0);
    check("ldx_q_drained", q.size(), 0);

    push_one(K_LDY, 0);
    pulse(S_LDY);
    repeat (4) @(negedge clk);
    check("ldy_q_drained", q.size(), 0);

    // Toggle: one update_single then a draw sweep
    push_one(K_SGL, 0);
    push_sweep(K_DRW);
    pulse(S_TGL);
    measure(bl, pc);
    check("toggle_busy_len", bl, 66);
    check("toggle_plot_cnt", pc, 64);
    check("toggle_gen_count", int'(gen_count), 3);

    // Edit keys during DRAW are ignored
    push_gen();
    pulse(S_STEP);
    wait_strobe(K_DRW, 5);
    pulse(S_TGL);
    pulse(S_LDX);
    measure(bl, pc);
    repeat (20) @(negedge clk);
    check("busy_edit_ignored", int'(busy), 0);
    check("busy_edit_q_empty", q.size(), 0);
    check("busy_edit_gen_count", int'(gen_count), 4);

    // Auto-run for 1000 cycles
`ifdef LIFE_CTRL_AUTORUN_EN
    push_gen(); push_gen(); push_gen();
    exp_gen = 7;
`else
    exp_gen = 4;
`endif
    rises = 0; last_rise = -1; prev_busy = int'(busy);
    run = 1'b1;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      if (busy && prev_busy == 0) begin
        rises++;
        if (last_rise >= 0) check("autorun_spacing", c - last_rise, P);
        last_rise = c;
      end
      prev_busy = int'(busy);
    end
    run = 1'b0;
    t = 0;
    while (busy && t < 500) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
`ifdef LIFE_CTRL_AUTORUN_EN
    check("autorun_generations", rises, 3);
`else
    check("autorun_generations", rises, 0);
`endif
    check("autorun_gen_count", int'(gen_count), exp_gen);
    check("autorun_q_empty", q.size(), 0);

    // Reset mid-CALC aborts immediately
    push_gen();
    pulse(S_STEP);
    wait_strobe(K_TMP, 20);
    resetN = 1'b0;
    #1;
    check("abort_update_temp", int'(update_temp), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_xy", int'(xy_position), 0);
    check("abort_gen", int'(gen_count), 0);
    check("abort_strobes", act_kind(), K_NONE);
    q.delete();
    @(negedge clk);
    resetN = 1'b1;
    repeat (10) @(negedge clk);
    check("post_abort_busy", int'(busy), 0);
    check("post_abort_gen", int'(gen_count), 0);
    check("post_abort_plot", int'(plot), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/life_ctrl.md
# life_ctrl

Generation sequencer for the Game of Life datapath. It sits directly upstream of the datapath and drives all of its strobes: the cell-index sweep (`xy_position`), user-edit loads and toggles, and the three per-generation sweeps (compute, commit, draw). It also produces the `plot` strobe for the VGA adapter downstream. One step or one auto-run tick advances the 8x8 grid by exactly one generation and redraws it.

## Interface
- `GEN_PERIOD`, default 12_500_000: clock cycles between auto-run generations (4 Hz at 50 MHz); minimum 256.
- `clk` in 1: system clock; all state changes on the rising edge.
- `resetN` in 1: asynchronous, active-low reset.
- `step` in 1: single-cycle pulse; requests one generation.
- `run` in 1: level; auto-advance every `GEN_PERIOD` cycles while high.
- `ld_x_key`, `ld_y_key`, `toggle_key` in 1 each: single-cycle user-edit pulses.
- `ld_x`, `ld_y`, `update_single` out 1 each: datapath edit strobes.
- `update_temp`, `update_grid`, `drw` out 1 each: datapath sweep strobes.
- `xy_position` out 7: cell index `{1'b0, idx[5:0]}`.
- `plot` out 1: VGA write enable; equals `drw` delayed one cycle.
- `busy` out 1: high in every state except IDLE.
- `gen_count` out 8: generations completed; wraps 255 -> 0.

## Operation
States:
- IDLE
- LDX, LDY, TOGGLE: one cycle each.
- CALC, COMMIT, DRAW: 64 cycles each, `idx` 0..63.
- FLUSH: one cycle.

IDLE arbitration, evaluated each cycle, highest priority first:
- `ld_x_key` -> LDX
- `ld_y_key` -> LDY
- `toggle_key` -> TOGGLE
- `step` or pending -> CALC
- auto tick -> CALC

Lower-priority events in the same cycle are dropped, except `step` and tick, which set pending.

Transitions:
- LDX -> IDLE, with `ld_x`=1.
- LDY -> IDLE, with `ld_y`=1.
- TOGGLE (`update_single`=1) -> DRAW.
- CALC (`update_temp`=1) -> COMMIT when `idx`=63.
- COMMIT (`update_grid`=1) -> DRAW when `idx`=63; `gen_count` increments on that exit.
- DRAW (`drw`=1) -> FLUSH when `idx`=63.
- FLUSH -> IDLE, with `plot`=1 and `drw`=0.

Request handling:
- `idx` resets to 0 on entry to each sweep state.
- `step` or tick arriving while `busy`=1 sets a one-deep pending flag. Further requests while pending are merged. The flag clears on entry to CALC.
- `ld_x_key`, `ld_y_key` and `toggle_key` are ignored while `busy`=1 (no queueing).

Rate divider:
- Counts down from `GEN_PERIOD-1` while `run`=1.
- At 0 it emits a one-cycle tick and reloads.
- `run`=0 reloads the counter and suppresses ticks.

Reset:
- `resetN` low: state IDLE, `idx`=0, pending=0, divider reloaded, `gen_count`=0.
- Every output is 0 during reset, including `xy_position`.
- Reset mid-sweep aborts immediately; no strobe completes.

## Timing
- All outputs are registered, Moore-style, from state and `idx`. A request sampled in IDLE at edge N gives the first strobe valid after edge N+1.
- Generation: 64 `update_temp` + 64 `update_grid` + 64 `drw` + 1 FLUSH = `busy` high for 193 consecutive cycles, then 1 IDLE cycle minimum before the next CALC.
- Toggle: 1 + 64 + 1 = 66 busy cycles.
- `plot` is high for exactly 64 cycles per draw: the first DRAW cycle's successor through FLUSH.
- `xy_position` holds its last value in IDLE.

## Configuration
- `LIFE_CTRL_AUTORUN_EN` defined: rate divider present; `run` is honoured.
- Undefined: no divider logic; `run` is ignored; generations come only from `step`. All other behaviour is identical.

## Structure
- Package `life_pkg`:
  - `GRID_CELLS`=64
  - `IDX_W`=6
  - `XY_W`=7
  - state enum `life_state_t` (IDLE, LDX, LDY, TOGGLE, CALC, COMMIT, DRAW, FLUSH)
- Sub-module `life_rate_div`: the divider, parameterised by `GEN_PERIOD`, outputs `tick`. It is instantiated only under `LIFE_CTRL_AUTORUN_EN`.

## Test plan
- Assert `resetN` low during CALC at `idx`=20 -> all outputs 0 in the same cycle; after release, IDLE with `gen_count`=0.
- One `step` pulse -> `update_temp` high for 64 cycles with `xy_position` 0..63, then `update_grid` for 64, then `drw` for 64; `plot` lags `drw` by one; `busy` high for 193 cycles; `gen_count`=1.
- `step` pulse during COMMIT `idx`=10 -> after FLUSH, exactly one IDLE cycle, then a second CALC; final `gen_count`=2.
- `GEN_PERIOD`=300, `run`=1 for 1000 cycles -> 3 generations, with CALC entries 300 cycles apart; with the macro undefined -> 0 generations.
- `ld_x_key` and `toggle_key` in the same IDLE cycle -> single `ld_x` pulse, no `update_single`. A later `toggle_key` -> 1 cycle `update_single`, then 64 `drw`; `gen_count` unchanged.
- `toggle_key` during DRAW -> no `update_single` and no extra sweep.
